// File: rtl/alu_issue_ctrl.sv
// RV32I ALU issue front end: decodes instructions into the ALU control word,
// selects operands, and captures ALU results through a two-stage pipeline.
module alu_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [6:0]      ins,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            Zero,
  input  logic            Sign,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            res_zero,
  output logic            res_sign,
  output logic [4:0]      res_rd,
  output logic            res_we,
  output logic            res_illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            f7b5;
  logic            opb5;
  logic [4:0]      rd;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] sh_imm;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7b5   = in_instr[30];
  assign opb5   = in_instr[5];
  assign rd     = in_instr[11:7];
  assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign u_imm  = {in_instr[31:12], 12'b0};
  assign sh_imm = {27'b0, in_instr[24:20]};

  logic [6:0]      d_ins;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic            d_we;
  logic            d_ill;

  always_comb begin
    d_ins = '0;
    d_a   = '0;
    d_b   = '0;
    d_we  = 1'b0;
    d_ill = 1'b0;
    unique case (1'b1)
      (opc == OP_R): begin
        d_ins = {opb5, f7b5, f3, 2'b10};
        d_a   = in_rs1;
        d_b   = in_rs2;
        d_we  = 1'b1;
      end
      (opc == OP_I): begin
        d_a  = in_rs1;
        d_we = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d_ins = {opb5, f7b5, f3, 2'b10};
          d_b   = sh_imm;
        end else begin
          d_ins = {opb5, 1'b0, f3, 2'b10};
          d_b   = i_imm;
        end
      end
      (opc == OP_LD): begin
        d_ins = {opb5, 6'b0};
        d_a   = in_rs1;
        d_b   = i_imm;
        d_we  = 1'b1;
      end
      (opc == OP_ST): begin
        d_ins = {opb5, 6'b0};
        d_a   = in_rs1;
        d_b   = s_imm;
      end
      (opc == OP_BR): begin
        d_ins = {opb5, f7b5, f3, 2'b01};
        d_a   = in_rs1;
        d_b   = in_rs2;
      end
      (opc == OP_LUI): begin
        d_ins = {opb5, f7b5, f3, 2'b00};
        d_b   = u_imm;
        d_we  = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (SUPPRESS_X0 && rd == 5'd0) d_we = 1'b0;
  end

  logic       s1_valid;
  logic [4:0] s1_rd;
  logic       s1_we;
  logic       s1_ill;
  logic       s2_load;
  logic       accept;

  assign s2_load  = s1_valid & (~res_valid | res_ready);
  assign in_ready = ~reset & (~s1_valid | s2_load);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      ins      <= '0;
      SrcAE    <= '0;
      SrcBE    <= '0;
      s1_rd    <= '0;
      s1_we    <= 1'b0;
      s1_ill   <= 1'b0;
    end else begin
      s1_valid <= accept | (s1_valid & ~s2_load);
      if (accept) begin
        ins    <= d_ins;
        SrcAE  <= d_a;
        SrcBE  <= d_b;
        s1_rd  <= rd;
        s1_we  <= d_we;
        s1_ill <= d_ill;
      end
    end
  end

  // ALU output is combinational from S1, so it is captured on the S1->S2 move
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_sign    <= 1'b0;
      res_rd      <= '0;
      res_we      <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      res_valid <= s2_load | (res_valid & ~res_ready);
      if (s2_load) begin
        res_data    <= ALUResult;
        res_zero    <= Zero;
        res_sign    <= Sign;
        res_rd      <= s1_rd;
        res_we      <= s1_we;
        res_illegal <= s1_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed encodings, stalls, reset, and
// randomized traffic against an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [6:0]  ins;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Sign;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_sign;
  logic [4:0]  res_rd;
  logic        res_we;
  logic        res_illegal;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [6:0]  ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
    logic        sign;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  alu_issue_ctrl #(.XLEN(32), .SUPPRESS_X0(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ins(ins), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .ALUResult(ALUResult), .Zero(Zero), .Sign(Sign),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_sign(res_sign),
    .res_rd(res_rd), .res_we(res_we), .res_illegal(res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RV32I arithmetic by funct3; alt selects sub / sra
  function automatic logic [31:0] alu_sem(input logic [2:0] f,
                                          input logic alt,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    case (f)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return {31'b0, $signed(x) < $signed(y)};
      3'd3: return {31'b0, x < y};
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  // Stand-in for ALU_unit, driven by the control word
  logic [31:0] alu_y;
  always_comb begin
    case (ins[1:0])
      2'b00:   alu_y = SrcAE + SrcBE;
      2'b01:   alu_y = SrcAE - SrcBE;
      default: alu_y = alu_sem(ins[4:2], ins[5], SrcAE, SrcBE);
    endcase
  end
  assign ALUResult = alu_y;
  assign Zero = (alu_y == 32'd0);
  assign Sign = alu_y[31];

  function automatic exp_t ref_model(input logic [31:0] i,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t e;
    logic [2:0]  f3;
    logic [31:0] ii, is, iu;
    f3 = i[14:12];
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    iu = {i[31:12], 12'b0};
    e = '0;
    e.rd = i[11:7];
    case (i[6:0])
      7'b0110011: begin
        e.ins = {1'b1, i[30], f3, 2'b10};
        e.a = a; e.b = b; e.we = 1'b1;
        e.data = alu_sem(f3, i[30], a, b);
      end
      7'b0010011: begin
        e.a = a; e.we = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'b0, i[24:20]};
          e.ins = {1'b0, i[30], f3, 2'b10};
        end else begin
          e.b = ii;
          e.ins = {2'b00, f3, 2'b10};
        end
        e.data = alu_sem(f3, (f3 == 3'd5) && i[30], a, e.b);
      end
      7'b0000011: begin
        e.a = a; e.b = ii; e.data = a + ii; e.we = 1'b1;
      end
      7'b0100011: begin
        e.ins = 7'h40; e.a = a; e.b = is; e.data = a + is;
      end
      7'b1100011: begin
        e.ins = {1'b1, i[30], f3, 2'b01};
        e.a = a; e.b = b; e.data = a - b;
      end
      7'b0110111: begin
        e.ins = {1'b1, i[30], f3, 2'b00};
        e.b = iu; e.data = iu; e.we = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.we = 1'b0;
    e.zero = (e.data == 32'd0);
    e.sign = e.data[31];
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [2:0]  f3;
    logic [4:0]  rd, r1, r2;
    logic [11:0] im;
    logic [6:0]  hi;
    logic [6:0]  op;
    f3 = 3'($urandom_range(0, 7));
    rd = 5'($urandom);
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    im = 12'($urandom);
    case ($urandom_range(0, 6))
      0: begin
        hi = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
             ? 7'h20 : 7'h00;
        return {hi, r2, r1, f3, rd, 7'b0110011};
      end
      1: begin
        if (f3 == 3'd1) im = {7'h00, r2};
        else if (f3 == 3'd5)
          im = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2};
        return {im, r1, f3, rd, 7'b0010011};
      end
      2: return {im, r1, f3, rd, 7'b0000011};
      3: return {im[11:5], r2, r1, f3, im[4:0], 7'b0100011};
      4: return {im[11:5], r2, r1, f3, rd, 7'b1100011};
      5: return {im, r1, f3, rd, 7'b0110111};
      default: begin
        case ($urandom_range(0, 3))
          0: op = 7'h7F;
          1: op = 7'h6F;
          2: op = 7'h17;
          default: op = 7'h00;
        endcase
        return {im, r1, f3, rd, op};
      end
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ins, SrcAE, SrcBE, res_valid, res_data, res_zero, res_sign,
         res_rd, res_we, res_illegal, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ins=%h A=%h B=%h rv=%b rd=%h in_ready=%b required all 0",
               ins, SrcAE, SrcBE, res_valid, res_data, in_ready);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b res_valid=%b required 1/0",
               in_ready, res_valid);
    end
  endtask

  task automatic test_encode();
    logic [31:0] vi [4];
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [6:0]  xi [4];
    logic [31:0] xb [4];
    logic [31:0] xd [4];
    logic [4:0]  xr [4];
    logic [1:0]  xzs [4];
    vi = '{32'h002081B3, 32'h402082B3, 32'hFFF00093, 32'h4040D113};
    va = '{32'd5, 32'd3, 32'd0, 32'h80000000};
    vb = '{32'd7, 32'd3, 32'd0, 32'd0};
    xi = '{7'h42, 7'h62, 7'h02, 7'h36};
    xb = '{32'd7, 32'd3, 32'hFFFFFFFF, 32'd4};
    xd = '{32'd12, 32'd0, 32'hFFFFFFFF, 32'hF8000000};
    xr = '{5'd3, 5'd5, 5'd1, 5'd2};
    xzs = '{2'b00, 2'b10, 2'b01, 2'b01};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = vi[k];
      in_rs1 = va[k]; in_rs2 = vb[k]; res_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL enc%0d_in_ready: got %b required 1", k, in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ins !== xi[k] || SrcBE !== xb[k] || SrcAE !== va[k] ||
          res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL enc%0d_issue: ins=%h A=%h B=%h rv=%b required %h %h %h 0",
                 k, ins, SrcAE, SrcBE, res_valid, xi[k], va[k], xb[k]);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== xd[k] ||
          {res_zero, res_sign} !== xzs[k] || res_rd !== xr[k] ||
          res_we !== 1'b1 || res_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL enc%0d_result: v=%b d=%h zs=%b rd=%0d we=%b il=%b required 1 %h %b %0d 1 0",
                 k, res_valid, res_data, {res_zero, res_sign}, res_rd,
                 res_we, res_illegal, xd[k], xzs[k], xr[k]);
      end
    end
  endtask

  task automatic test_illegal();
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    in_rs1 = 32'h12345678; in_rs2 = 32'h9ABCDEF0; res_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ins !== 7'h00 || SrcAE !== 32'd0 || SrcBE !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_issue: ins=%h A=%h B=%h required 0 0 0",
               ins, SrcAE, SrcBE);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_illegal !== 1'b1 || res_we !== 1'b0 ||
        res_rd !== 5'd31) begin
      n_fail++;
      $display("FAIL illegal_result: v=%b il=%b we=%b rd=%0d required 1 1 0 31",
               res_valid, res_illegal, res_we, res_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bi [3];
    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic [4:0]  br [3];
    int k, got;
    logic saw_block;
    bi = '{32'h002081B3, 32'h00208233, 32'h00208333};
    ba = '{32'd1, 32'd10, 32'd100};
    bb = '{32'd2, 32'd20, 32'd200};
    br = '{5'd3, 5'd4, 5'd6};
    k = 0; got = 0; saw_block = 1'b0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        in_valid = 1'b1; in_instr = bi[k]; in_rs1 = ba[k]; in_rs2 = bb[k];
      end else in_valid = 1'b0;
      res_ready = (c >= 5);
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (res_valid && res_ready) begin
        n_cmp++;
        if (res_data !== ba[got] + bb[got] || res_rd !== br[got]) begin
          n_fail++;
          $display("FAIL b2b_result%0d: d=%0d rd=%0d required %0d %0d",
                   got, res_data, res_rd, ba[got] + bb[got], br[got]);
        end
        got++;
      end
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (saw_block !== 1'b1 || got != 3) begin
      n_fail++;
      $display("FAIL b2b_flow: blocked=%b results=%0d required 1 3",
               saw_block, got);
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    res_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h002081B3; in_rs1 = 32'd1; in_rs2 = 32'd1;
    @(posedge clk); #1 in_instr = 32'h00208233;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_full: rv=%b in_ready=%b required 1 0",
               res_valid, in_ready);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || ins !== 7'h00 ||
        SrcAE !== 32'd0 || res_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midflight_reset: rv=%b in_ready=%b ins=%h A=%h d=%h required 0",
               res_valid, in_ready, ins, SrcAE, res_data);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_release: in_ready=%b rv=%b required 1 0",
               in_ready, res_valid);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t cur, iss, e;
    logic hold, chk;
    hold = 1'b0; chk = 1'b0; cur = '0; iss = '0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (c >= 500) in_valid = 1'b0;
      else if (!hold) begin
        if ($urandom_range(0, 3) != 0) begin
          in_instr = gen_instr();
          in_rs1 = $urandom;
          in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
          in_valid = 1'b1;
          cur = ref_model(in_instr, in_rs1, in_rs2);
        end else in_valid = 1'b0;
      end
      res_ready = (c >= 500) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (chk) begin
        n_cmp++;
        if ({ins, SrcAE, SrcBE} !== {iss.ins, iss.a, iss.b}) begin
          n_fail++;
          $display("FAIL rand_issue: ins=%h A=%h B=%h required %h %h %h",
                   ins, SrcAE, SrcBE, iss.ins, iss.a, iss.b);
        end
        chk = 1'b0;
      end
      if (res_valid && res_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: result d=%h with none outstanding",
                   res_data);
        end else begin
          e = q.pop_front();
          if ({res_data, res_zero, res_sign, res_rd, res_we, res_illegal} !==
              {e.data, e.zero, e.sign, e.rd, e.we, e.ill}) begin
            n_fail++;
            $display("FAIL rand_result: d=%h z=%b s=%b rd=%0d we=%b il=%b required %h %b %b %0d %b %b",
                     res_data, res_zero, res_sign, res_rd, res_we,
                     res_illegal, e.data, e.zero, e.sign, e.rd, e.we, e.ill);
          end
        end
      end
      hold = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        q.push_back(cur);
        iss = cur;
        chk = 1'b1;
      end
    end
    n_cmp++;
    if (q.size() != 0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: outstanding=%0d rv=%b required 0 0",
               q.size(), res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
